// File: rtl/radar_stream_rx.sv
// radar_stream_rx
//   Accepts wide radar beats (LANES samples, two pixel positions per beat),
//   frames them with a small IDLE/FRAME state machine, buffers accepted beats
//   in a FIFO and serializes them one sample per out_valid/out_ready word.
// Ports
//   clock, reset                 : rising-edge clock, async active-high reset
//   row_idx1/col_idx1            : coordinates of lanes 0..LANES/2-1
//   row_idx2/col_idx2            : coordinates of lanes LANES/2..LANES-1
//   channel_num                  : channel tag of the beat
//   data_start/data_end          : first/last beat of a frame (qualified by data_vaild)
//   data_vaild                   : beat qualifier
//   pixel_out                    : beat payload, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   out_data/out_row/out_col/out_channel/out_first/out_last/out_valid, out_ready
//                                : serialized word stream with handshake
//   frame_count, beat_count      : completed frames / beats written to the FIFO
//   err_overflow/orphan/restart  : sticky error flags
module radar_stream_rx #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [10:0]                 row_idx1,
   input  logic [10:0]                 col_idx1,
   input  logic [10:0]                 row_idx2,
   input  logic [10:0]                 col_idx2,
   input  logic [3:0]                  channel_num,
   input  logic                        data_start,
   input  logic                        data_end,
   input  logic                        data_vaild,
   input  logic [DATA_WIDTH*LANES-1:0] pixel_out,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [10:0]                 out_row,
   output logic [10:0]                 out_col,
   output logic [3:0]                  out_channel,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_first,
   output logic                        out_last,
   output logic [15:0]                 frame_count,
   output logic [15:0]                 beat_count,
   output logic                        err_overflow,
   output logic                        err_orphan,
   output logic                        err_restart
);
   localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int HALF = LANES / 2;

   typedef struct packed {
      logic [DATA_WIDTH*LANES-1:0] payload;
      logic [10:0]                 row1, col1, row2, col2;
      logic [3:0]                  ch;
      logic                        first, last;
   } beat_t;

   typedef enum logic {IDLE, FRAME} state_t;

   state_t        state;
   beat_t         mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [LW-1:0] lane;

   logic  accept, full, wr_en, load, pop;
   beat_t head, wr_beat;

   // A beat is taken if it opens a frame or arrives inside one.
   assign accept = data_vaild && (state == FRAME || data_start);
   // Occupancy before this edge: a same-cycle pop does not make room.
   assign full   = (count == (AW+1)'(FIFO_DEPTH));
   assign wr_en  = accept && !full;
   assign head   = mem[rd_ptr];
   // Output register refills whenever it is empty or being consumed.
   assign load   = (count != '0) && (!out_valid || out_ready);
   assign pop    = load && (lane == LW'(LANES-1));

   assign wr_beat = '{payload: pixel_out, row1: row_idx1, col1: col_idx1,
                      row2: row_idx2, col2: col_idx2, ch: channel_num,
                      first: data_start, last: data_end};

   // Payload storage carries no reset; validity lives in count.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= wr_beat;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         lane         <= '0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_row      <= '0;
         out_col      <= '0;
         out_channel  <= '0;
         out_first    <= 1'b0;
         out_last     <= 1'b0;
         frame_count  <= '0;
         beat_count   <= '0;
         err_overflow <= 1'b0;
         err_orphan   <= 1'b0;
         err_restart  <= 1'b0;
      end else begin
         // framing
         if (data_vaild) begin
            case (state)
               IDLE: begin
                  if (!data_start)   err_orphan <= 1'b1;
                  else if (!data_end) state     <= FRAME;
               end
               FRAME: begin
                  if (data_start) err_restart <= 1'b1;
                  if (data_end)   state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
         if (accept && full) err_overflow <= 1'b1;

         // FIFO bookkeeping
         if (wr_en) begin
            wr_ptr     <= wr_ptr + 1'b1;
            beat_count <= beat_count + 16'd1;
            if (data_end) frame_count <= frame_count + 16'd1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // serializer
         if (load) begin
            out_valid   <= 1'b1;
            out_data    <= head.payload[lane*DATA_WIDTH +: DATA_WIDTH];
            out_row     <= (lane < LW'(HALF)) ? head.row1 : head.row2;
            out_col     <= (lane < LW'(HALF)) ? head.col1 : head.col2;
            out_channel <= head.ch;
            out_first   <= head.first && (lane == '0);
            out_last    <= head.last && (lane == LW'(LANES-1));
            lane        <= pop ? '0 : lane + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_radar_stream_rx.sv
module tb_radar_stream_rx;
   localparam int DW = 16, LN = 10, FD = 4;

   logic clock = 0, reset = 1;
   logic [10:0] row_idx1 = 0, col_idx1 = 0, row_idx2 = 0, col_idx2 = 0;
   logic [3:0]  channel_num = 0;
   logic data_start = 0, data_end = 0, data_vaild = 0, out_ready = 1;
   logic [DW*LN-1:0] pixel_out = '0;
   logic [DW-1:0] out_data;
   logic [10:0] out_row, out_col;
   logic [3:0] out_channel;
   logic out_valid, out_first, out_last, err_overflow, err_orphan, err_restart;
   logic [15:0] frame_count, beat_count;

   radar_stream_rx #(.DATA_WIDTH(DW), .LANES(LN), .FIFO_DEPTH(FD)) dut (
      .clock(clock), .reset(reset),
      .row_idx1(row_idx1), .col_idx1(col_idx1), .row_idx2(row_idx2), .col_idx2(col_idx2),
      .channel_num(channel_num), .data_start(data_start), .data_end(data_end),
      .data_vaild(data_vaild), .pixel_out(pixel_out),
      .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_channel(out_channel),
      .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
      .frame_count(frame_count), .beat_count(beat_count),
      .err_overflow(err_overflow), .err_orphan(err_orphan), .err_restart(err_restart));

   always #5 clock = ~clock;

   typedef struct {
      logic [DW-1:0] data;
      logic [10:0]   row, col;
      logic [3:0]    ch;
      logic          first, last;
      int            cyc;
   } word_t;

   int vectors = 0, miscompares = 0, cyc = 0, tmode = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: pending words as a flat queue, one held output word.
   word_t q[$];
   word_t m_cur, w;
   bit    m_hold, m_frame, m_ovf, m_orphan, m_restart, acc;
   logic [15:0] m_beats, m_frames;
   int    occ;

   always @(posedge clock) cyc++;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         q.delete();
         m_hold = 0; m_frame = 0; m_ovf = 0; m_orphan = 0; m_restart = 0;
         m_beats = 0; m_frames = 0;
      end else begin
         occ = (q.size() + LN - 1) / LN;  // beats still holding unsent words
         if ((!m_hold || out_ready) && q.size() > 0) begin
            m_cur = q.pop_front(); m_hold = 1;
         end else if (out_ready) m_hold = 0;
         if (data_vaild) begin
            acc = m_frame || data_start;
            if (!acc) m_orphan = 1;
            if (m_frame && data_start) m_restart = 1;
            if (acc) begin
               if (occ < FD) begin
                  for (int k = 0; k < LN; k++) begin
                     w.data  = pixel_out[k*DW +: DW];
                     w.row   = (k < LN/2) ? row_idx1 : row_idx2;
                     w.col   = (k < LN/2) ? col_idx1 : col_idx2;
                     w.ch    = channel_num;
                     w.first = data_start && (k == 0);
                     w.last  = data_end && (k == LN-1);
                     w.cyc   = 0;
                     q.push_back(w);
                  end
                  m_beats++;
                  if (data_end) m_frames++;
               end else m_ovf = 1;
               m_frame = !data_end;
            end
         end
      end
   end

   // Compare process plus a log of DUT handshakes for literal checks.
   word_t lg[$];
   always @(negedge clock) begin
      check("out_valid", out_valid, m_hold);
      if (m_hold) begin
         check("out_data", out_data, m_cur.data);
         check("out_row", out_row, m_cur.row);
         check("out_col", out_col, m_cur.col);
         check("out_channel", out_channel, m_cur.ch);
         check("out_first", out_first, m_cur.first);
         check("out_last", out_last, m_cur.last);
      end
      check("beat_count", beat_count, m_beats);
      check("frame_count", frame_count, m_frames);
      check("err_overflow", err_overflow, m_ovf);
      check("err_orphan", err_orphan, m_orphan);
      check("err_restart", err_restart, m_restart);
      if (!reset && out_valid && out_ready) begin
         w.data = out_data; w.row = out_row; w.col = out_col; w.ch = out_channel;
         w.first = out_first; w.last = out_last; w.cyc = cyc;
         lg.push_back(w);
      end
   end

   task automatic tick();
      @(posedge clock); #1;
      if (tmode == 1) out_ready = ~out_ready;
      else if (tmode == 2) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   function automatic logic [DW*LN-1:0] mkpay(input int base);
      logic [DW*LN-1:0] p;
      for (int k = 0; k < LN; k++) p[k*DW +: DW] = DW'(base + k);
      return p;
   endfunction

   task automatic send(input bit s, input bit e, input logic [3:0] ch,
                       input logic [10:0] r1, c1, r2, c2, input logic [DW*LN-1:0] p);
      data_vaild = 1; data_start = s; data_end = e; channel_num = ch;
      row_idx1 = r1; col_idx1 = c1; row_idx2 = r2; col_idx2 = c2; pixel_out = p;
      tick();
      data_vaild = 0; data_start = 0; data_end = 0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((q.size() != 0 || m_hold) && n < budget) begin tick(); n++; end
      check("drain_timeout", (q.size() != 0 || m_hold), 0);
   endtask

   task automatic do_reset();
      reset = 1; tick(); tick(); reset = 0;
   endtask

   int nf, nl, b0;

   initial begin
      tick(); tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_counts", {frame_count, beat_count}, 0);
      check("rst_flags", {err_overflow, err_orphan, err_restart}, 0);
      reset = 0;

      // single-beat frame, latency and literal word contents
      lg.delete();
      send(1, 1, 4'd3, 11'd5, 11'd7, 11'd6, 11'd8, mkpay(0));
      check("lat_edge_n", out_valid, 0);
      tick();
      check("lat_edge_n1", out_valid, 1);
      check("lat_word0", out_data, 0);
      drain(50);
      check("t1_words", lg.size(), 10);
      if (lg.size() == 10) begin
         check("t1_w0", {lg[0].data, lg[0].row, lg[0].col, lg[0].ch, lg[0].first, lg[0].last},
               {16'h0, 11'd5, 11'd7, 4'd3, 1'b1, 1'b0});
         check("t1_w4_row", lg[4].row, 5);
         check("t1_w5_row", lg[5].row, 6);
         check("t1_w9", {lg[9].data, lg[9].row, lg[9].col, lg[9].first, lg[9].last},
               {16'h9, 11'd6, 11'd8, 1'b0, 1'b1});
         check("t1_consecutive", lg[9].cyc - lg[0].cyc, 9);
      end
      check("t1_frames", frame_count, 1);
      check("t1_beats", beat_count, 1);

      // 3-beat frame with toggling ready
      lg.delete(); tmode = 1;
      send(1, 0, 4'd1, 11'd10, 11'd11, 11'd12, 11'd13, mkpay(16'h100));
      send(0, 0, 4'd1, 11'd14, 11'd15, 11'd16, 11'd17, mkpay(16'h200));
      send(0, 1, 4'd1, 11'd18, 11'd19, 11'd20, 11'd21, mkpay(16'h300));
      drain(300);
      tmode = 0; out_ready = 1;
      check("t2_words", lg.size(), 30);
      nf = 0; nl = 0;
      foreach (lg[i]) begin
         nf += lg[i].first; nl += lg[i].last;
         check("t2_order", lg[i].data, (i / 10 + 1) * 16'h100 + i % 10);
      end
      check("t2_firsts", nf, 1);
      check("t2_lasts", nl, 1);
      check("t2_frames", frame_count, 2);

      // overflow with ready held low
      lg.delete(); out_ready = 0; b0 = beat_count;
      send(1, 0, 4'd2, 11'd1, 11'd2, 11'd3, 11'd4, mkpay(16'h1000));
      for (int i = 1; i < 5; i++)
         send(0, 0, 4'd2, 11'd1, 11'd2, 11'd3, 11'd4, mkpay(16'h1000 + i * 16));
      send(0, 1, 4'd2, 11'd1, 11'd2, 11'd3, 11'd4, mkpay(16'h1050));
      check("t3_accepted", beat_count - b0, 4);
      check("t3_overflow", err_overflow, 1);
      out_ready = 1;
      drain(100);
      check("t3_words", lg.size(), 40);

      // orphan and restart
      do_reset(); lg.delete();
      send(0, 0, 4'd5, 11'd1, 11'd1, 11'd1, 11'd1, mkpay(16'h2000));
      repeat (12) tick();
      check("t4_orphan", err_orphan, 1);
      check("t4_beats", beat_count, 0);
      check("t4_no_output", lg.size(), 0);
      send(1, 0, 4'd5, 11'd1, 11'd1, 11'd1, 11'd1, mkpay(16'h2100));
      send(0, 0, 4'd5, 11'd1, 11'd1, 11'd1, 11'd1, mkpay(16'h2200));
      send(1, 0, 4'd5, 11'd1, 11'd1, 11'd1, 11'd1, mkpay(16'h2300));
      check("t4_restart", err_restart, 1);
      check("t4_frames_hold", frame_count, 0);
      send(0, 1, 4'd5, 11'd1, 11'd1, 11'd1, 11'd1, mkpay(16'h2400));
      check("t4_frames_end", frame_count, 1);
      drain(100);

      // reset in the middle of serialization
      send(1, 1, 4'd7, 11'd2, 11'd3, 11'd4, 11'd5, mkpay(16'h3000));
      repeat (5) tick();
      check("t5_word4", out_data, 16'h3004);
      reset = 1; #1;
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_counts", {frame_count, beat_count}, 0);
      tick(); tick(); reset = 0;
      lg.delete();
      send(1, 1, 4'd9, 11'd40, 11'd41, 11'd42, 11'd43, mkpay(16'h500));
      drain(50);
      check("t5_words", lg.size(), 10);
      foreach (lg[i]) check("t5_data", lg[i].data, 16'h500 + i);
      check("t5_frames", frame_count, 1);

      // randomized traffic
      tmode = 2;
      for (int it = 0; it < 600; it++) begin
         if (it == 300) begin reset = 1; tick(); reset = 0; end
         data_vaild = ($urandom_range(0, 1) == 1);
         data_start = ($urandom_range(0, 3) == 0);
         data_end   = ($urandom_range(0, 3) == 0);
         channel_num = 4'($urandom);
         row_idx1 = 11'($urandom); col_idx1 = 11'($urandom);
         row_idx2 = 11'($urandom); col_idx2 = 11'($urandom);
         for (int k = 0; k < LN; k++) pixel_out[k*DW +: DW] = DW'($urandom);
         tick();
      end
      data_vaild = 0; data_start = 0; data_end = 0;
      tmode = 0; out_ready = 1;
      drain(500);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
